// File: rtl/data_transmission_channel.sv
//------------------------------------------------------------------------------
// Module   : data_transmission_channel
// Purpose  : Parity-protected link model: TX parity + fault-injecting channel
//            register, then RX parity check. Optional macro
//            DATA_TRANSMISSION_CHANNEL_ERR_COUNT_EN adds a saturating
//            error_count output.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module data_transmission_channel #(
   parameter int DATA_WIDTH = 8,
   parameter bit ODD_PARITY = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  inject_error,
   output logic [DATA_WIDTH-1:0] received_data,
   output logic                  error_detected
`ifdef DATA_TRANSMISSION_CHANNEL_ERR_COUNT_EN
   ,
   output logic [7:0]            error_count
`endif
);

   localparam int c_FRAME_W = DATA_WIDTH + 1;
   localparam int c_POS_W   = $clog2(c_FRAME_W);
   localparam logic [c_POS_W-1:0] c_POS_MAX = c_POS_W'(DATA_WIDTH);

   // Reset frame carries the parity bit that makes an all-zero payload consistent.
   localparam logic [c_FRAME_W-1:0] c_FRAME_RST = {ODD_PARITY, {DATA_WIDTH{1'b0}}};

   logic [c_FRAME_W-1:0]  r_frame;
   logic [c_POS_W-1:0]    r_err_pos;
   logic [DATA_WIDTH-1:0] r_received_data;
   logic                  r_error_detected;

   logic                  w_parity;
   logic [c_FRAME_W-1:0]  w_mask;

   always_comb begin
      w_parity = (^data_in) ^ ODD_PARITY;
      w_mask   = '0;
      if (inject_error) begin
         w_mask = c_FRAME_W'(1) << r_err_pos;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_frame   <= c_FRAME_RST;
         r_err_pos <= '0;
      end else begin
         r_frame <= {w_parity, data_in} ^ w_mask;
         if (inject_error) begin
            r_err_pos <= (r_err_pos == c_POS_MAX) ? '0 : r_err_pos + c_POS_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_received_data  <= '0;
         r_error_detected <= 1'b0;
      end else begin
         r_received_data  <= r_frame[DATA_WIDTH-1:0];
         r_error_detected <= (^r_frame) ^ ODD_PARITY;
      end
   end

   assign received_data  = r_received_data;
   assign error_detected = r_error_detected;

`ifdef DATA_TRANSMISSION_CHANNEL_ERR_COUNT_EN
   logic [7:0] r_error_count;

   // Counts flagged output cycles, one edge behind the flag itself.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_error_count <= 8'd0;
      end else if (r_error_detected && (r_error_count != 8'hFF)) begin
         r_error_count <= r_error_count + 8'd1;
      end
   end

   assign error_count = r_error_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_data_transmission_channel.sv
//------------------------------------------------------------------------------
// Module   : tb_data_transmission_channel
// Purpose  : Directed scoreboard bench for data_transmission_channel.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_data_transmission_channel;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] data_in = 8'h00;
   logic       inject_error = 1'b0;
   logic [7:0] received_data;
   logic       error_detected;
`ifdef DATA_TRANSMISSION_CHANNEL_ERR_COUNT_EN
   logic [7:0] error_count;
`endif

   int checks = 0;
   int errors = 0;
   int cnt_model = 0;
   logic [8:0] q[$];

   data_transmission_channel #(.DATA_WIDTH(8), .ODD_PARITY(1'b0)) dut (
      .clk            (clk),
      .rst            (rst),
      .data_in        (data_in),
      .inject_error   (inject_error),
      .received_data  (received_data),
      .error_detected (error_detected)
`ifdef DATA_TRANSMISSION_CHANNEL_ERR_COUNT_EN
      ,
      .error_count    (error_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Asynchronous reset pulse of 10 ns, checked while still asserted.
   task automatic do_reset();
      #2 rst = 1'b0;
      #1;
      chk("rst_data", 32'(received_data), 32'h00);
      chk("rst_err", 32'(error_detected), 32'h0);
`ifdef DATA_TRANSMISSION_CHANNEL_ERR_COUNT_EN
      chk("rst_cnt", 32'(error_count), 32'h0);
`endif
      #9 rst = 1'b1;
      q.delete();
      cnt_model = 0;
   endtask

   task automatic step(input logic [7:0] d, input logic inj,
                       input logic [7:0] ed, input logic ee);
      logic [8:0] e;
      @(negedge clk);
      data_in      = d;
      inject_error = inj;
      q.push_back({ee, ed});
      @(posedge clk);
      #1;
      if (q.size() > 1) begin
         e = q.pop_front();
`ifdef DATA_TRANSMISSION_CHANNEL_ERR_COUNT_EN
         chk("err_count", 32'(error_count), 32'(cnt_model));
`endif
         chk("data", 32'(received_data), 32'(e[7:0]));
         chk("flag", 32'(error_detected), 32'(e[8]));
         if (e[8] && cnt_model < 255) cnt_model++;
      end
   endtask

   initial begin
      logic [7:0] r;
      do_reset();

      step(8'hAA, 1'b0, 8'hAA, 1'b0);
      step(8'hCC, 1'b1, 8'hCD, 1'b1);
      step(8'hF0, 1'b0, 8'hF0, 1'b0);
      step(8'h01, 1'b0, 8'h01, 1'b0);
      step(8'h55, 1'b1, 8'h57, 1'b1);
      step(8'hE0, 1'b1, 8'hE4, 1'b1);
      step(8'hFF, 1'b1, 8'hF7, 1'b1);
      for (int i = 0; i < 4; i++) begin
         r = 8'($urandom);
         step(r, 1'b0, r, 1'b0);
      end
      step(8'h00, 1'b0, 8'h00, 1'b0);

      do_reset();
      for (int i = 0; i < 9; i++) begin
         r = (i < 8) ? 8'(1 << i) : 8'h00;
         step(8'h00, 1'b1, r, 1'b1);
      end
      step(8'h00, 1'b1, 8'h01, 1'b1);
      step(8'h3C, 1'b0, 8'h3C, 1'b0);

      do_reset();
      step(8'hCC, 1'b0, 8'hCC, 1'b0);
      step(8'h0F, 1'b1, 8'h0E, 1'b1);
      step(8'h00, 1'b0, 8'h00, 1'b0);
      step(8'h00, 1'b0, 8'h00, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/data_transmission_channel.md
Name: data_transmission_channel

Overview:
- Models a parity-protected point-to-point link: transmitter stage, channel stage with controllable fault injection, receiver stage.
- Transmitter appends an even-parity bit to each byte. The channel can flip one frame bit on request. The receiver checks parity and flags mismatches.
- Used as a self-contained error-detection demonstrator and as a link model in system-level benches. Data is streamed every clock, with no handshake.

Parameters:
- DATA_WIDTH, 8, payload width in bits; frame width is DATA_WIDTH+1.
- ODD_PARITY, 0, 0 = even parity, 1 = odd parity.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- data_in  input  DATA_WIDTH  payload byte, sampled every rising edge.
- inject_error  input  1  sampled with data_in; when 1, corrupts that byte's frame in the channel.
- received_data  output  DATA_WIDTH  payload as delivered by the receiver; registered; may be corrupted, no correction.
- error_detected  output  1  registered parity-mismatch flag, aligned with received_data.

Behaviour:
- Reset (rst=0, asynchronous, any time): clear the following to 0.
  - frame register, received_data, error_detected.
  - error-position counter err_pos.
  - Reset frame {parity=0, data=0} is parity-consistent for even parity. With ODD_PARITY=1, the reset parity bit is 1 so no spurious error follows release.
- TX+channel stage, each rising edge out of reset:
  - p = XOR-reduce(data_in) XOR ODD_PARITY.
  - frame_q <= {p, data_in} XOR mask.
  - mask = (1 << err_pos) if inject_error=1, else 0.
  - Frame bit index: 0..DATA_WIDTH-1 = data bits, DATA_WIDTH = parity bit.
- err_pos handling:
  - Increments only on edges where inject_error=1.
  - Wraps from DATA_WIDTH to 0, giving positions 0..8 for default width.
  - Holds otherwise.
- RX stage, each rising edge:
  - received_data <= frame_q[DATA_WIDTH-1:0].
  - error_detected <= XOR-reduce(frame_q) XOR ODD_PARITY. 1 means mismatch.
- Latency:
  - data_in/inject_error sampled at edge N appear on received_data/error_detected after edge N+1.
  - Two register stages; one result per cycle; fully pipelined.
- Single-bit injection is always detected, including parity-bit flips. Those deliver unchanged data with error_detected=1.
- Back-to-back injections use consecutive positions; no bubble.
- Reset mid-stream discards in-flight frames. The first outputs after release correspond to bytes sampled after release.
- Outputs never X after reset; X on data_in propagates, no masking required.

Optional Feature:
- Macro: DATA_TRANSMISSION_CHANNEL_ERR_COUNT_EN.
- Defined:
  - Adds output error_count, 8 bits: count of cycles where the registered error_detected = 1.
  - Increments on the edge following each flagged cycle.
  - Saturates at 255 and clears on reset.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Release reset; drive 8'hAA, inject=0 -> two edges later received_data=8'hAA, error_detected=0.
- Drive 8'hCC, inject=1 as first injection (err_pos=0) -> received_data=8'hCD, error_detected=1. Following clean 8'hF0 and 8'h01 -> unchanged, flag 0.
- Successive injections on 8'h55, 8'hE0, 8'hFF -> 8'h57, 8'hE4, 8'hF7, each with error_detected=1. Proves err_pos 1,2,3.
- Nine consecutive injections on 8'h00 -> bits 0..7 flipped in turn (8'h01..8'h80). 9th gives data 8'h00 with error_detected=1 (parity bit flipped). 10th wraps to 8'h01.
- Assert rst=0 mid-stream for 10 ns -> outputs 0 immediately (asynchronous). After release, 8'hCC clean -> 8'hCC/0; 8'h0F inject -> 8'h0E/1 (err_pos restarted at 0).
- With DATA_TRANSMISSION_CHANNEL_ERR_COUNT_EN defined, run the 4 injections above -> error_count=4. A reset returns it to 0.
